// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// Retires one quotient bit per clock through a shift and an invert-plus-carry-in subtract.
// A zero divisor bypasses the iteration and completes in a single cycle.
// The convention for a zero divisor is quotient = all ones and remainder = dividend.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q;     // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH:0]   rem_q;     // partial remainder R
    logic [WIDTH-1:0] dsr_q;     // latched divisor D
    logic [CntW-1:0]  cnt_q;

    logic             divisor_zero;
    logic             last_step;
    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] diff_full;
    logic             carry;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             unused_rem_msb;

    assign divisor_zero = (divisor == '0);
    assign last_step    = (cnt_q == LastCnt);

    // One restoring step: the carry-out of S + ~D + 1 is set exactly when S >= D.
    assign partial   = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign diff_full = {1'b0, partial} + {1'b0, ~{1'b0, dsr_q}} + (WIDTH+2)'(1);
    assign carry     = diff_full[WIDTH+1];
    assign rem_nxt   = carry ? diff_full[WIDTH:0] : partial;
    assign acc_nxt   = {acc_q[WIDTH-2:0], carry};

    // R always stays below D, so the MSB of R never feeds the next step.
    assign unused_rem_msb = rem_q[WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start matters only in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = divisor_zero ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StRun:   busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            acc_q <= dividend;
                            dsr_q <= divisor;
                            rem_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                StRun: begin
                    acc_q <= acc_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_step) begin
                        quotient    <= acc_nxt;
                        remainder   <= rem_nxt[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of the 4-bit sequential divider.
// Covers reset, edge operands, divide by zero, ignored starts, mid-run reset and a full sweep.
module tb_seq_divider;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp;
    int n_err;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge in the idle cycle after done.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
        int           done_at;
        int           busy_cnt;
        int           overlap;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        string        tag;
        tag      = $sformatf("%0d/%0d", a, b);
        exp_q    = (b == 0) ? 4'hF : a / b;
        exp_r    = (b == 0) ? a : a % b;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_at  = 0;
        busy_cnt = 0;
        overlap  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
        end
        check({tag, " done sample"}, done_at, (b == 0) ? 1 : W + 1);
        check({tag, " busy cycles"}, busy_cnt, (b == 0) ? 0 : W);
        check({tag, " busy&done"}, overlap, 0);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div_by_zero"}, div_by_zero, (b == 0) ? 1 : 0);
        @(negedge clk);
        check({tag, " done drop"}, done, 0);
        check({tag, " busy after"}, busy, 0);
        check({tag, " q hold"}, quotient, exp_q);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic case and edge operands
        do_div(4'd13, 4'd4);
        do_div(4'd15, 4'd1);
        do_div(4'd3, 4'd7);
        do_div(4'd15, 4'd15);

        // Divide by zero, then a normal op must clear the flag
        do_div(4'd9, 4'd0);
        do_div(4'd8, 4'd2);

        // Extra starts during RUN and during DONE are ignored
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);                       // E0
        #1 start = 1'b0;
        @(posedge clk);                       // E1
        #1;
        start    = 1'b1;
        dividend = 4'd2;
        divisor  = 4'd1;
        @(posedge clk);                       // E2 samples the ignored start
        #1;
        start    = 1'b0;
        dividend = 4'd13;
        divisor  = 4'd4;
        check("ign busy E2", busy, 1);
        @(posedge clk);                       // E3
        #1 check("ign busy E3", busy, 1);
        @(posedge clk);                       // E4: done cycle begins
        #1;
        check("ign done", done, 1);
        check("ign busy in done", busy, 0);
        check("ign quotient", quotient, 3);
        check("ign remainder", remainder, 1);
        start    = 1'b1;
        dividend = 4'd2;
        divisor  = 4'd1;
        @(posedge clk);                       // E5 samples start while in DONE
        #1 start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("ign hold done %0d", i), done, 0);
            check($sformatf("ign hold busy %0d", i), busy, 0);
            check($sformatf("ign hold q %0d", i), quotient, 3);
            check($sformatf("ign hold r %0d", i), remainder, 1);
        end

        // Asynchronous reset mid-RUN aborts with no done pulse
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst quotient", quotient, 0);
        check("arst remainder", remainder, 0);
        check("arst dbz", div_by_zero, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("arst no done %0d", i), done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post rst no done %0d", i), done, 0);
        end
        do_div(4'd14, 4'd3);

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(W'(a), W'(b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
